sqrt_arb: RTL and testbench
===========================

Name: sqrt_arb

Overview:
- Round-robin arbiter and sequencer that shares one sqrt unit among NREQ requesters.
- Accepts operand requests and issues them to the sqrt unit one at a time through its enb/dt/busy interface.
- Captures the result when busy falls and returns it to the owning requester with a done pulse.
- Sits between client blocks and a single sqrt instance; a watchdog flags a sqrt unit that never starts.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 8, operand and result width; must match the sqrt unit.
- TMO, 8, maximum cycles in WAIT_BUSY before a start timeout (≥1).

Ports:
- clk  input  1  clock, rising edge.
- rstn_i  input  1  reset, asynchronous, active-low.
- req_i  input  NREQ  per-requester request level.
- dt_req_i  input  NREQ*DW  operands; requester n uses bits [n*DW +: DW].
- ack_o  output  NREQ  one-cycle pulse: operand accepted.
- done_o  output  NREQ  one-cycle pulse: result ready on dt_res_o.
- dt_res_o  output  DW  last result; held until the next DONE.
- err_o  output  1  one-cycle pulse with done_o on timeout.
- busy_o  output  1  high whenever state ≠ IDLE.
- sqrt_enb_o  output  1  start pulse to the sqrt unit.
- sqrt_dt_o  output  DW  operand to the sqrt unit; valid while sqrt_enb_o=1.
- sqrt_busy_i  input  1  sqrt unit busy.
- sqrt_dt_i  input  DW  sqrt result; valid when sqrt_busy_i falls.

Behaviour:
- Reset, asynchronous: state=IDLE, rr_ptr=0, owner=0, all outputs 0 (including dt_res_o and sqrt_dt_o), timeout counter=0.
- Reset mid-operation aborts everything. No done_o is generated for the aborted request.
- All outputs are registered/state-decoded; there are no combinational paths from req_i to the outputs.

FSM:
- IDLE: if |req_i and sqrt_busy_i==0, do the following, then go to ISSUE.
  - Select winner w = first set req_i bit searching upward from rr_ptr, wrapping modulo NREQ.
  - Latch owner=w and operand=dt_req_i[w].
  - If sqrt_busy_i==1, grant nothing and stay in IDLE.
- ISSUE: exactly 1 cycle.
  - sqrt_enb_o=1, sqrt_dt_o=operand, ack_o[owner]=1.
  - Clear the counter, go to WAIT_BUSY.
- WAIT_BUSY:
  - If sqrt_busy_i==1, go to RUN.
  - Else if counter==TMO-1, set err_flag and go to DONE.
  - Else counter++.
- RUN: when sqrt_busy_i==0, capture sqrt_dt_i into dt_res_o and go to DONE.
- DONE: exactly 1 cycle.
  - done_o[owner]=1 and err_o=err_flag.
  - On error, dt_res_o=0.
  - rr_ptr = (owner+1) mod NREQ; clear err_flag; go to IDLE.

Request handshake:
- Requester holds req_i and its operand stable until it sees ack_o.
- Requester may drop req_i after the ack cycle.
- req_i dropped before the grant sample means no grant and no penalty.
- req_i still high after done_o is a new request. It competes normally, and rr_ptr guarantees other requesters go first.

Timing and ordering:
- Latency, no timeout, sqrt busy of B cycles: req sampled at cycle t; ISSUE at t+1; busy seen at t+2 or later; done_o at t+B+3 minimum. Sequencer overhead is 4 cycles per operation.
- Simultaneous requests are served in rr_ptr order; there is no starvation, and the worst-case wait is NREQ-1 operations.
- Only one operation is outstanding; sqrt_enb_o never asserts outside ISSUE.
- If busy is already high in the first WAIT_BUSY cycle, go to RUN immediately.

Width rules:
- Counter width is $clog2(TMO+1).
- rr_ptr width is $clog2(NREQ), with explicit wrap at NREQ-1 for non-power-of-2 NREQ.

Test Plan:
- Single request n=0, dt=64, sqrt busy 5 cycles → ack_o[0] at t+1; sqrt_enb_o=1 with sqrt_dt_o=64; done_o[0] with dt_res_o=8, err_o=0; busy_o returns 0.
- All four requesters assert at once with dt 1,4,9,16 from rr_ptr=0 → done order 0,1,2,3 with results 1,2,3,4; exactly one ack and one done per requester.
- Requester 2 keeps req_i high while requester 0 requests → order 2,0,2: rr_ptr skips to 3, wraps to 0, then 2; no back-to-back grants to 2 while 0 is waiting.
- sqrt_busy_i stuck at 0 after ISSUE, TMO=8 → done_o[owner]=1 and err_o=1 exactly 8 cycles after the first WAIT_BUSY cycle; dt_res_o=0; the next request proceeds normally.
- sqrt_busy_i held high externally while req_i[1]=1 → no ack and no sqrt_enb_o; grant occurs on the first cycle busy is sampled low.
- rstn_i asserted during RUN → all outputs 0 asynchronously; after release, a new request for dt=225 returns 15 with no stale done_o.

Source files
------------

// File: rtl/sqrt_arb.sv
// sqrt_arb: round-robin arbiter/sequencer sharing one sqrt unit among NREQ requesters.
// One operation in flight at a time. A watchdog reports a sqrt unit that never raises busy.
module sqrt_arb #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned DW   = 8,
   parameter int unsigned TMO  = 8
) (
   input  logic               clk,
   input  logic               rstn_i,
   input  logic [NREQ-1:0]    req_i,
   input  logic [NREQ*DW-1:0] dt_req_i,
   output logic [NREQ-1:0]    ack_o,
   output logic [NREQ-1:0]    done_o,
   output logic [DW-1:0]      dt_res_o,
   output logic               err_o,
   output logic               busy_o,
   output logic               sqrt_enb_o,
   output logic [DW-1:0]      sqrt_dt_o,
   input  logic               sqrt_busy_i,
   input  logic [DW-1:0]      sqrt_dt_i
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CW = $clog2(TMO + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_BUSY,
      S_RUN,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]       owner_q, owner_d;
   logic [DW-1:0]       opnd_q, opnd_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                err_flag_q, err_flag_d;
   logic [NREQ-1:0]     ack_q, ack_d;
   logic [NREQ-1:0]     done_q, done_d;
   logic [DW-1:0]       res_q, res_d;
   logic [DW-1:0]       sdt_q, sdt_d;
   logic                err_q, err_d;
   logic                busy_q, busy_d;
   logic                enb_q, enb_d;

   logic                win_found_c;
   logic [PW-1:0]       win_c;
   logic [PW:0]         scan_c;

   // Round-robin winner: first pending request at or above rr_ptr, wrapping at NREQ.
   always_comb begin
      win_found_c = 1'b0;
      win_c       = '0;
      scan_c      = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         scan_c = {1'b0, rr_ptr_q} + (PW+1)'(i);
         if (scan_c >= (PW+1)'(NREQ)) begin
            scan_c = scan_c - (PW+1)'(NREQ);
         end
         if (!win_found_c && req_i[scan_c[PW-1:0]]) begin
            win_found_c = 1'b1;
            win_c       = scan_c[PW-1:0];
         end
      end
   end

   // Next-state logic and registered-output decode of the next state.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      opnd_d     = opnd_q;
      cnt_d      = cnt_q;
      err_flag_d = err_flag_q;
      res_d      = res_q;

      case (state_q)
         S_IDLE: begin
            if (win_found_c && !sqrt_busy_i) begin
               owner_d = win_c;
               opnd_d  = dt_req_i[32'(win_c) * DW +: DW];
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = '0;
            state_d = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (sqrt_busy_i) begin
               state_d = S_RUN;
            end else if (cnt_q == CW'(TMO - 1)) begin
               err_flag_d = 1'b1;
               res_d      = '0;
               state_d    = S_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_RUN: begin
            if (!sqrt_busy_i) begin
               res_d   = sqrt_dt_i;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            rr_ptr_d   = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);
            err_flag_d = 1'b0;
            state_d    = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      ack_d  = (state_d == S_ISSUE) ? (NREQ'(1) << owner_d) : '0;
      enb_d  = (state_d == S_ISSUE);
      sdt_d  = (state_d == S_ISSUE) ? opnd_d : '0;
      done_d = (state_d == S_DONE) ? (NREQ'(1) << owner_d) : '0;
      err_d  = (state_d == S_DONE) && err_flag_d;
      busy_d = (state_d != S_IDLE);
   end

   // State and output registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q    <= S_IDLE;
         rr_ptr_q   <= '0;
         owner_q    <= '0;
         opnd_q     <= '0;
         cnt_q      <= '0;
         err_flag_q <= 1'b0;
         ack_q      <= '0;
         done_q     <= '0;
         res_q      <= '0;
         sdt_q      <= '0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         enb_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         owner_q    <= owner_d;
         opnd_q     <= opnd_d;
         cnt_q      <= cnt_d;
         err_flag_q <= err_flag_d;
         ack_q      <= ack_d;
         done_q     <= done_d;
         res_q      <= res_d;
         sdt_q      <= sdt_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
         enb_q      <= enb_d;
      end
   end

   assign ack_o      = ack_q;
   assign done_o     = done_q;
   assign dt_res_o   = res_q;
   assign err_o      = err_q;
   assign busy_o     = busy_q;
   assign sqrt_enb_o = enb_q;
   assign sqrt_dt_o  = sdt_q;

endmodule

// File: tb/tb_sqrt_arb.sv
// tb_sqrt_arb: directed bench with a behavioural sqrt unit and ack/done scoreboard queues.
module tb_sqrt_arb;

   localparam int unsigned NREQ = 4;
   localparam int unsigned DW   = 8;
   localparam int unsigned TMO  = 8;

   typedef struct {
      int           idx;
      logic [DW-1:0] val;
      logic         err;
   } exp_t;

   logic               clk = 1'b0;
   logic               rstn;
   logic [NREQ-1:0]    req_i;
   logic [NREQ*DW-1:0] dt_req_i;
   logic [NREQ-1:0]    ack_o;
   logic [NREQ-1:0]    done_o;
   logic [DW-1:0]      dt_res_o;
   logic               err_o;
   logic               busy_o;
   logic               sqrt_enb_o;
   logic [DW-1:0]      sqrt_dt_o;
   logic               sqrt_busy_i;
   logic [DW-1:0]      sqrt_dt_i = '0;

   // sqrt unit model controls
   logic               mdl_busy = 1'b0;
   logic               ext_busy = 1'b0;
   logic               stuck    = 1'b0;
   int                 lat      = 5;
   int                 rem      = 0;
   logic [DW-1:0]      mdl_opnd = '0;

   logic [NREQ-1:0]    hold_mask;
   exp_t               ack_q[$];
   exp_t               done_q[$];
   int                 cyc = 0;
   int                 last_ack_cyc = 0;
   int                 last_done_cyc = 0;
   int                 n_cmp = 0;
   int                 n_mis = 0;
   int                 mark;

   assign sqrt_busy_i = mdl_busy | ext_busy;

   always #5 clk = ~clk;

   sqrt_arb #(.NREQ(NREQ), .DW(DW), .TMO(TMO)) dut (
      .clk        (clk),
      .rstn_i     (rstn),
      .req_i      (req_i),
      .dt_req_i   (dt_req_i),
      .ack_o      (ack_o),
      .done_o     (done_o),
      .dt_res_o   (dt_res_o),
      .err_o      (err_o),
      .busy_o     (busy_o),
      .sqrt_enb_o (sqrt_enb_o),
      .sqrt_dt_o  (sqrt_dt_o),
      .sqrt_busy_i(sqrt_busy_i),
      .sqrt_dt_i  (sqrt_dt_i)
   );

   function automatic logic [DW-1:0] isqrt(input logic [DW-1:0] x);
      int r = 0;
      while ((r + 1) * (r + 1) <= int'(x)) r++;
      return DW'(r);
   endfunction

   // Behavioural sqrt unit: busy for lat cycles after a start, result valid as busy falls.
   always @(negedge clk) begin
      if (sqrt_enb_o && !stuck) begin
         mdl_busy = 1'b1;
         rem      = lat;
         mdl_opnd = sqrt_dt_o;
      end else if (mdl_busy) begin
         if (rem == 0) begin
            mdl_busy  = 1'b0;
            sqrt_dt_i = isqrt(mdl_opnd);
         end else begin
            rem = rem - 1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int idx, input logic [DW-1:0] opnd,
                       input logic [DW-1:0] res, input logic err);
      exp_t a;
      exp_t d;
      a.idx = idx; a.val = opnd; a.err = 1'b0;
      d.idx = idx; d.val = res;  d.err = err;
      ack_q.push_back(a);
      done_q.push_back(d);
   endtask

   task automatic set_req(input int n, input logic [DW-1:0] d);
      dt_req_i[n*DW +: DW] = d;
      req_i[n] = 1'b1;
   endtask

   // One clock: sample after the edge, score ack/done, drop acked requests not held.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      check("enb_vs_ack", 32'(sqrt_enb_o), 32'(ack_o != '0));
      if (ack_o != '0) begin
         last_ack_cyc = cyc;
         if (ack_q.size() == 0) begin
            check("ack_unexpected", 32'(ack_o), 32'd0);
         end else begin
            e = ack_q.pop_front();
            check("ack_idx", 32'(ack_o), 32'd1 << e.idx);
            check("sqrt_dt", 32'(sqrt_dt_o), 32'(e.val));
         end
         req_i = req_i & ~(ack_o & ~hold_mask);
      end
      if (done_o != '0) begin
         last_done_cyc = cyc;
         if (done_q.size() == 0) begin
            check("done_unexpected", 32'(done_o), 32'd0);
         end else begin
            e = done_q.pop_front();
            check("done_idx", 32'(done_o), 32'd1 << e.idx);
            check("dt_res", 32'(dt_res_o), 32'(e.val));
            check("err", 32'(err_o), 32'(e.err));
            check("busy_in_done", 32'(busy_o), 32'd1);
         end
      end
   endtask

   task automatic wait_drain(input string tag, input int max);
      int n = 0;
      while ((ack_q.size() != 0 || done_q.size() != 0 || busy_o) && n < max) begin
         tick();
         n++;
      end
      check(tag, 32'(n < max), 32'd1);
   endtask

   task automatic wait_acks(input string tag, input int remaining, input int max);
      int n = 0;
      while (ack_q.size() > remaining && n < max) begin
         tick();
         n++;
      end
      check(tag, 32'(n < max), 32'd1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ack"},   32'(ack_o),      32'd0);
      check({tag, "_done"},  32'(done_o),     32'd0);
      check({tag, "_res"},   32'(dt_res_o),   32'd0);
      check({tag, "_err"},   32'(err_o),      32'd0);
      check({tag, "_busy"},  32'(busy_o),     32'd0);
      check({tag, "_enb"},   32'(sqrt_enb_o), 32'd0);
      check({tag, "_sdt"},   32'(sqrt_dt_o),  32'd0);
   endtask

   task automatic apply_reset();
      rstn  = 1'b0;
      req_i = '0;
      tick();
      tick();
      rstn = 1'b1;
      tick();
   endtask

   // Directed sequence.
   initial begin
      rstn      = 1'b0;
      req_i     = '0;
      dt_req_i  = '0;
      hold_mask = '0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rstn = 1'b1;
      tick();

      // Single request, 5-cycle sqrt.
      mark = cyc;
      set_req(0, 8'd64);
      push(0, 8'd64, 8'd8, 1'b0);
      wait_drain("t1_drain", 100);
      check("t1_ack_lat",  32'(last_ack_cyc - mark),  32'd1);
      check("t1_done_lat", 32'(last_done_cyc - mark), 32'd8);

      // All four at once from rr_ptr=0.
      apply_reset();
      lat = 2;
      set_req(0, 8'd1);
      set_req(1, 8'd4);
      set_req(2, 8'd9);
      set_req(3, 8'd16);
      push(0, 8'd1,  8'd1, 1'b0);
      push(1, 8'd4,  8'd2, 1'b0);
      push(2, 8'd9,  8'd3, 1'b0);
      push(3, 8'd16, 8'd4, 1'b0);
      wait_drain("t2_drain", 200);

      // Requester 2 holds request; requester 0 joins: order 2,0,2.
      hold_mask = 4'b0100;
      set_req(2, 8'd49);
      push(2, 8'd49,  8'd7,  1'b0);
      push(0, 8'd100, 8'd10, 1'b0);
      push(2, 8'd49,  8'd7,  1'b0);
      wait_acks("t3_first_ack", 2, 50);
      set_req(0, 8'd100);
      wait_acks("t3_all_acks", 0, 100);
      req_i[2]  = 1'b0;
      hold_mask = '0;
      wait_drain("t3_drain", 100);

      // Start timeout: sqrt unit never raises busy.
      stuck = 1'b1;
      set_req(1, 8'd50);
      push(1, 8'd50, 8'd0, 1'b1);
      wait_drain("t4_drain", 100);
      check("t4_tmo_lat", 32'(last_done_cyc - last_ack_cyc), 32'(TMO + 1));
      stuck = 1'b0;
      set_req(1, 8'd81);
      push(1, 8'd81, 8'd9, 1'b0);
      wait_drain("t4_next_drain", 100);

      // External busy blocks the grant until it drops.
      ext_busy = 1'b1;
      set_req(1, 8'd36);
      push(1, 8'd36, 8'd6, 1'b0);
      repeat (10) tick();
      check("t5_no_grant", 32'(ack_q.size()), 32'd1);
      mark     = cyc;
      ext_busy = 1'b0;
      wait_drain("t5_drain", 100);
      check("t5_grant_lat", 32'(last_ack_cyc - mark), 32'd1);

      // Reset during RUN aborts; no stale done afterwards.
      lat = 20;
      set_req(0, 8'd144);
      push(0, 8'd144, 8'd12, 1'b0);
      wait_acks("t6_ack", 0, 50);
      repeat (4) tick();
      rstn = 1'b0;
      #1;
      check_all_zero("t6_async");
      done_q.delete();
      tick();
      tick();
      rstn = 1'b1;
      lat  = 3;
      set_req(0, 8'd225);
      push(0, 8'd225, 8'd15, 1'b0);
      wait_drain("t6_drain", 150);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   // Hard stop should the sequence ever stall outside a bounded wait.
   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
